// File: rtl/lc3b_control_fsm.sv
// LC-3b mp0 multicycle Moore control unit: fetch, decode, execute, memory, writeback.
// Optional macro LC3B_CTRL_PERF_EN adds cycle_count / instr_count performance ports.
module lc3b_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        br_en,
    input  logic        mem_resp,
    output logic        pcmux_sel,
    output logic        storemux_sel,
    output logic        marmux_sel,
    output logic        mdrmux_sel,
    output logic        alumux_sel,
    output logic        regfilemux_sel,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_regfile,
    output logic        load_cc,
    output logic [2:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic        mem_timeout
`ifdef LC3B_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    localparam int unsigned CNT_W = 32;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
        S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_mem;
    logic             expire;

    assign in_mem = (state == S_FETCH2) || (state == S_LDR1) || (state == S_STR2);

    // Wait budget runs out this cycle; a simultaneous mem_resp takes priority.
    assign expire = (MEM_WAIT_MAX != 0) && in_mem && !mem_resp &&
                    (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: begin
                if (mem_resp)    state_next = S_FETCH3;
                else if (expire) state_next = S_FETCH1;
            end
            S_FETCH3: state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD:         state_next = S_ADD;
                    OP_AND:         state_next = S_AND;
                    OP_NOT:         state_next = S_NOT;
                    OP_BR:          state_next = S_BR;
                    OP_LDR, OP_STR: state_next = S_CALC_ADDR;
                    default:        state_next = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: state_next = S_FETCH1;
            S_BR:        state_next = br_en ? S_BR_TAKEN : S_FETCH1;
            S_BR_TAKEN:  state_next = S_FETCH1;
            S_CALC_ADDR: state_next = (opcode == OP_LDR) ? S_LDR1 : S_STR1;
            S_LDR1: begin
                if (mem_resp)    state_next = S_LDR2;
                else if (expire) state_next = S_FETCH1;
            end
            S_LDR2: state_next = S_FETCH1;
            S_STR1: state_next = S_STR2;
            S_STR2: begin
                if (mem_resp || expire) state_next = S_FETCH1;
            end
            default: state_next = S_FETCH1;
        endcase
    end

    // State register and saturating per-memory-state wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH1;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (in_mem && (state_next == state)) begin
                if ((MEM_WAIT_MAX != 0) && (wait_cnt != CNT_W'(MEM_WAIT_MAX)))
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Moore output decode; reset masks everything except the byte enables.
    always_comb begin
        pcmux_sel       = 1'b0;
        storemux_sel    = 1'b0;
        marmux_sel      = 1'b0;
        mdrmux_sel      = 1'b0;
        alumux_sel      = 1'b0;
        regfilemux_sel  = 1'b0;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_regfile    = 1'b0;
        load_cc         = 1'b0;
        alu_op          = ALU_ADD;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        mem_timeout     = rst_n && expire;
        if (rst_n) begin
            case (state)
                S_FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                end
                S_FETCH2, S_LDR1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                end
                S_FETCH3: load_ir = 1'b1;
                S_ADD, S_AND, S_NOT: begin
                    alu_op       = (state == S_AND) ? ALU_AND :
                                   (state == S_NOT) ? ALU_NOT : ALU_ADD;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                S_BR_TAKEN: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                end
                S_CALC_ADDR: begin
                    alumux_sel = 1'b1;
                    load_mar   = 1'b1;
                end
                S_LDR2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                end
                S_STR1: begin
                    storemux_sel = 1'b1;
                    alu_op       = ALU_PASS;
                    load_mdr     = 1'b1;
                end
                S_STR2: mem_write = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LC3B_CTRL_PERF_EN
    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (state_next == S_FETCH1)
                instr_count <= instr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_control_fsm.sv
// Scoreboard bench for lc3b_control_fsm (instance built with MEM_WAIT_MAX=4).
module tb_lc3b_control_fsm;

    typedef enum logic [3:0] {
        F1, F2, F3, DEC, ADD, AND, NOT, BR, BRT, CALC, LDR1, LDR2, STR1, STR2
    } st_e;

    typedef struct packed {
        logic       r;
        logic [3:0] op;
        logic       be;
        logic       resp;
        st_e        st;
        logic       to;
    } cyc_t;

    typedef struct packed {
        logic       pcmux, storemux, marmux, mdrmux, alumux, rfmux;
        logic       ld_pc, ld_ir, ld_mar, ld_mdr, ld_rf, ld_cc;
        logic [2:0] aluop;
        logic       rd, wr;
        logic [1:0] ben;
        logic       to;
    } outv_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        br_en;
    logic        mem_resp;
    logic        pcmux_sel, storemux_sel, marmux_sel, mdrmux_sel, alumux_sel, regfilemux_sel;
    logic        load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
    logic [2:0]  alu_op;
    logic        mem_read, mem_write;
    logic [1:0]  mem_byte_enable;
    logic        mem_timeout;
`ifdef LC3B_CTRL_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    int tests = 0;
    int fails = 0;
    outv_t sb_q[$];
    outv_t act_q[$];

    lc3b_control_fsm #(.MEM_WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_en(br_en), .mem_resp(mem_resp),
        .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel), .marmux_sel(marmux_sel),
        .mdrmux_sel(mdrmux_sel), .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
        .load_pc(load_pc), .load_ir(load_ir), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_regfile(load_regfile), .load_cc(load_cc), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_timeout(mem_timeout)
`ifdef LC3B_CTRL_PERF_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic cyc_t mk(input logic r, input logic [3:0] op, input logic be,
                                input logic resp, input st_e st, input logic to);
        cyc_t c;
        c.r = r; c.op = op; c.be = be; c.resp = resp; c.st = st; c.to = to;
        return c;
    endfunction

    // Reference output table derived from the state/action list.
    function automatic outv_t exp_of(input cyc_t c);
        outv_t o;
        o = '0;
        o.ben = 2'b11;
        if (!c.r) return o;
        case (c.st)
            F1:   begin o.marmux = 1; o.ld_mar = 1; o.ld_pc = 1; end
            F2, LDR1: begin o.rd = 1; o.mdrmux = 1; o.ld_mdr = 1; end
            F3:   o.ld_ir = 1;
            ADD:  begin o.aluop = 3'd0; o.ld_rf = 1; o.ld_cc = 1; end
            AND:  begin o.aluop = 3'd1; o.ld_rf = 1; o.ld_cc = 1; end
            NOT:  begin o.aluop = 3'd2; o.ld_rf = 1; o.ld_cc = 1; end
            BRT:  begin o.pcmux = 1; o.ld_pc = 1; end
            CALC: begin o.alumux = 1; o.ld_mar = 1; end
            LDR2: begin o.rfmux = 1; o.ld_rf = 1; o.ld_cc = 1; end
            STR1: begin o.storemux = 1; o.aluop = 3'd3; o.ld_mdr = 1; end
            STR2: o.wr = 1;
            default: ;
        endcase
        o.to = c.to;
        return o;
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.pcmux = pcmux_sel; o.storemux = storemux_sel; o.marmux = marmux_sel;
        o.mdrmux = mdrmux_sel; o.alumux = alumux_sel; o.rfmux = regfilemux_sel;
        o.ld_pc = load_pc; o.ld_ir = load_ir; o.ld_mar = load_mar; o.ld_mdr = load_mdr;
        o.ld_rf = load_regfile; o.ld_cc = load_cc; o.aluop = alu_op;
        o.rd = mem_read; o.wr = mem_write; o.ben = mem_byte_enable; o.to = mem_timeout;
        return o;
    endfunction

    // Drive one cycle, push its expectation, capture the DUT response.
    task automatic apply(input cyc_t c);
        @(negedge clk);
        rst_n = c.r; opcode = c.op; br_en = c.be; mem_resp = c.resp;
        sb_q.push_back(exp_of(c));
        #1;
        act_q.push_back(sample());
    endtask

    task automatic test_reset();
        outv_t e, a;
        apply(mk(0, 4'h1, 0, 0, F1, 0));
        apply(mk(0, 4'h1, 0, 1, F1, 0));
        for (int i = 0; sb_q.size() > 0; i++) begin
            e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL reset cyc%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    task automatic test_alu();
        outv_t e, a;
        logic [3:0] ops [3];
        st_e sts [3];
        cyc_t seq[$];
`ifdef LC3B_CTRL_PERF_EN
        logic [31:0] ic0, cc0, ic1, cc1;
`endif
        ops[0] = 4'b0001; ops[1] = 4'b0101; ops[2] = 4'b1001;
        sts[0] = ADD;     sts[1] = AND;     sts[2] = NOT;
        for (int k = 0; k < 3; k++) begin
            seq = {};
            seq.push_back(mk(1, ops[k], 0, 0, F1, 0));
            seq.push_back(mk(1, ops[k], 0, 1, F2, 0));
            seq.push_back(mk(1, ops[k], 0, 0, F3, 0));
            seq.push_back(mk(1, ops[k], 0, 0, DEC, 0));
            seq.push_back(mk(1, ops[k], 0, 0, sts[k], 0));
            for (int i = 0; i < seq.size(); i++) begin
                apply(seq[i]);
`ifdef LC3B_CTRL_PERF_EN
                if (k == 0 && i == 0) begin ic0 = instr_count; cc0 = cycle_count; end
`endif
            end
`ifdef LC3B_CTRL_PERF_EN
            if (k == 0) begin
                @(posedge clk); #1;
                ic1 = instr_count; cc1 = cycle_count;
                tests++;
                if (ic1 - ic0 !== 32'd1) begin
                    fails++;
                    $display("FAIL perf_instr: got delta %0d expected 1", ic1 - ic0);
                end
                tests++;
                if (cc1 - cc0 !== 32'd5) begin
                    fails++;
                    $display("FAIL perf_cycle: got delta %0d expected 5", cc1 - cc0);
                end
            end
`endif
            for (int i = 0; sb_q.size() > 0; i++) begin
                e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL alu op%h cyc%0d: got %h expected %h", ops[k], i, a, e);
                end
            end
        end
    endtask

    task automatic test_branch();
        outv_t e, a;
        for (int t = 1; t >= 0; t--) begin
            apply(mk(1, 4'h0, 1'(t), 0, F1, 0));
            apply(mk(1, 4'h0, 1'(t), 1, F2, 0));
            apply(mk(1, 4'h0, 1'(t), 0, F3, 0));
            apply(mk(1, 4'h0, 1'(t), 0, DEC, 0));
            apply(mk(1, 4'h0, 1'(t), 0, BR, 0));
            if (t == 1) apply(mk(1, 4'h0, 1, 0, BRT, 0));
            for (int i = 0; sb_q.size() > 0; i++) begin
                e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL branch taken=%0d cyc%0d: got %h expected %h", t, i, a, e);
                end
            end
        end
    endtask

    task automatic test_ldr();
        outv_t e, a;
        apply(mk(1, 4'h6, 0, 0, F1, 0));
        apply(mk(1, 4'h6, 0, 1, F2, 0));
        apply(mk(1, 4'h6, 0, 0, F3, 0));
        apply(mk(1, 4'h6, 0, 0, DEC, 0));
        apply(mk(1, 4'h6, 0, 0, CALC, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 0));
        apply(mk(1, 4'h6, 0, 1, LDR1, 0));
        apply(mk(1, 4'h6, 0, 0, LDR2, 0));
        for (int i = 0; sb_q.size() > 0; i++) begin
            e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL ldr cyc%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    task automatic test_str();
        outv_t e, a;
        apply(mk(1, 4'h7, 0, 0, F1, 0));
        apply(mk(1, 4'h7, 0, 0, F2, 0));
        apply(mk(1, 4'h7, 0, 1, F2, 0));
        apply(mk(1, 4'h7, 0, 0, F3, 0));
        apply(mk(1, 4'h7, 0, 0, DEC, 0));
        apply(mk(1, 4'h7, 0, 0, CALC, 0));
        apply(mk(1, 4'h7, 0, 0, STR1, 0));
        apply(mk(1, 4'h7, 0, 0, STR2, 0));
        apply(mk(1, 4'h7, 0, 1, STR2, 0));
        for (int i = 0; sb_q.size() > 0; i++) begin
            e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL str cyc%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    task automatic test_reset_mid_and_nop();
        outv_t e, a;
        apply(mk(1, 4'hF, 0, 0, F1, 0));
        apply(mk(1, 4'hF, 0, 0, F2, 0));
        apply(mk(0, 4'hF, 0, 0, F2, 0));
        apply(mk(1, 4'hF, 0, 0, F1, 0));
        apply(mk(1, 4'hF, 0, 1, F2, 0));
        apply(mk(1, 4'hF, 0, 0, F3, 0));
        apply(mk(1, 4'hF, 0, 0, DEC, 0));
        for (int i = 0; sb_q.size() > 0; i++) begin
            e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL reset_mid_nop cyc%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    task automatic test_timeout();
        outv_t e, a;
        apply(mk(1, 4'h6, 0, 0, F1, 0));
        apply(mk(1, 4'h6, 0, 0, F2, 0));
        apply(mk(1, 4'h6, 0, 0, F2, 0));
        apply(mk(1, 4'h6, 0, 0, F2, 0));
        apply(mk(1, 4'h6, 0, 1, F2, 0));
        apply(mk(1, 4'h6, 0, 0, F3, 0));
        apply(mk(1, 4'h6, 0, 0, DEC, 0));
        apply(mk(1, 4'h6, 0, 0, CALC, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 0));
        apply(mk(1, 4'h6, 0, 0, LDR1, 1));
        apply(mk(1, 4'h6, 0, 0, F1, 0));
        for (int i = 0; sb_q.size() > 0; i++) begin
            e = sb_q.pop_front(); a = act_q.pop_front(); tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL timeout cyc%0d: got %h expected %h", i, a, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 4'h0; br_en = 1'b0; mem_resp = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_ldr();
        test_str();
        test_reset_mid_and_nop();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
